ttt_turn_controller: RTL
========================

// Module: ttt_turn_controller
// PURPOSE
//  Turn sequencer for the tic-tac-toe game. Accepts human (X) moves from switches + Input button,
//  requests O moves from the AI move generator over a req/valid handshake, owns both board
//  registers, detects win/draw. Sits between the button/switch front end and the AI + VGA renderer.
// PARAMETERS
//  AI_TIMEOUT   64  cycles to wait for ai_valid before the fallback move is used (>=2)
//  X_FIRST      1   1: X moves first after reset/new game; 0: O (AI) moves first
// PORTS
//  clk          in   1  system clock, 100 MHz
//  clr_n        in   1  asynchronous active-low reset
//  new_game     in   1  sync level, debounced Reset button; clears board
//  btn_input    in   1  sync level, debounced Input button; rising edge = submit move
//  move_sel     in   4  human cell index 0..8 (row-major, bit i of board = cell i)
//  ai_req       out  1  request to AI; held high until ai_valid
//  ai_valid     in   1  AI move available this cycle
//  ai_move      in   9  AI move, one-hot cell
//  x_state      out  9  X occupancy
//  o_state      out  9  O occupancy
//  o_turn       out  1  1 while waiting on AI
//  illegal      out  1  1-cycle pulse: human move rejected
//  game_over    out  1  game finished
//  winner       out  2  00 none, 01 X, 10 O, 11 draw
//  move_count   out  4  cells filled, 0..9
// BEHAVIOUR
//  - clr_n low: all outputs 0, FSM -> X_WAIT (X_FIRST=1) else AI_REQ; ai_req rises 1 cycle after release.
//  - All outputs registered. btn_input edge detector register reset to 0 (button held through reset is not a press).
//  - States: X_WAIT, X_CHECK, AI_REQ, AI_WAIT, O_CHECK, DONE.
//  - X_WAIT: on rising edge of btn_input, if move_sel<=8 and cell empty in x_state|o_state:
//    set x_state bit next cycle, move_count+1, -> X_CHECK. Otherwise illegal pulses 1 cycle, stay.
//  - X_CHECK (1 cycle): X three-in-row -> DONE, winner=01; else move_count==9 -> DONE, winner=11;
//    else -> AI_REQ.
//  - AI_REQ: assert ai_req, o_turn=1, clear timeout counter, -> AI_WAIT.
//  - AI_WAIT: ai_req stays 1. ai_valid with ai_move one-hot AND empty cell -> set o_state bit;
//    ai_valid with invalid move (zero, multi-hot, occupied) OR counter reaches AI_TIMEOUT ->
//    set lowest-index empty cell instead. Either way ai_req drops same edge, move_count+1, -> O_CHECK.
//    ai_valid while not in AI_WAIT is ignored.
//  - O_CHECK: O three-in-row -> DONE, winner=10; board full -> DONE, winner=11; else -> X_WAIT, o_turn=0.
//  - DONE: game_over=1, board frozen, btn_input ignored.
//  - new_game high (any state, priority over every other event incl. same-cycle ai_valid/btn edge):
//    boards, move_count, winner, game_over, illegal cleared next edge, ai_req dropped, -> reset-entry state.
//    Held high: stays cleared. AI that answers after abort must be ignored.
//  - Latency: button edge -> x_state update 1 cycle; -> ai_req 3 cycles.
//  - Win = any of 8 lines (rows 0-1-2, 3-4-5, 6-7-8; cols; diags 0-4-8, 2-4-6). Win beats draw on 9th move.
//  - Invariant: x_state & o_state == 0; popcount(x|o)==move_count.
// STRUCTURE
//  - Shared package ttt_pkg: board width 9, WIN_LINES[8] masks, winner codes, state encoding.
//  - Sub-module ttt_line_check: combinational 9-bit board -> has_line; instantiated twice (X, O).
//  - Lowest-empty priority encoder local to this module.
// TESTING
//  1. Reset, X_FIRST=1, move_sel=4, press -> x_state=000010000 next cycle, ai_req 3 cycles after edge.
//  2. Press with move_sel=4 again (occupied) and move_sel=9 -> illegal 1-cycle pulse each, boards unchanged.
//  3. X on 0,1,2 with AI answering 3,4 -> after third X: winner=01, game_over=1, ai_req never re-asserted.
//  4. AI silent AI_TIMEOUT cycles after X=0 -> o_state=000000010; AI returns occupied 000000001 -> lowest empty taken.
//  5. Full drawn game (X 0,2,3,7,5; O 1,4,6,8 scripted) -> move_count=9, winner=11.
//  6. new_game asserted in AI_WAIT same cycle as ai_valid -> board clear, ai_req=0, late ai_valid ignored.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: board geometry, winning-line masks,
// winner codes and turn-sequencer state encoding.
package ttt_pkg;

    localparam int BOARD_W = 9;
    localparam int N_LINES = 8;

    // Bit i of a board is cell i, row-major from the top-left corner.
    localparam logic [N_LINES-1:0][BOARD_W-1:0] WIN_LINES = {
        9'b001_010_100,  // diagonal 2-4-6
        9'b100_010_001,  // diagonal 0-4-8
        9'b100_100_100,  // column 2-5-8
        9'b010_010_010,  // column 1-4-7
        9'b001_001_001,  // column 0-3-6
        9'b111_000_000,  // row 6-7-8
        9'b000_111_000,  // row 3-4-5
        9'b000_000_111   // row 0-1-2
    };

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_X    = 2'b01,
        WIN_O    = 2'b10,
        WIN_DRAW = 2'b11
    } winner_e;

    typedef enum logic [2:0] {
        S_X_WAIT,
        S_X_CHECK,
        S_AI_REQ,
        S_AI_WAIT,
        S_O_CHECK,
        S_DONE
    } state_e;

endpackage

// File: rtl/ttt_line_check.sv
// Combinational three-in-a-row detector for one player's occupancy board.
module ttt_line_check
    import ttt_pkg::*;
(
    input  logic [BOARD_W-1:0] board,
    output logic               has_line
);

    always_comb begin
        // NOTE: default first so every path assigns has_line and no latch is inferred.
        has_line = 1'b0;
        for (int i = 0; i < N_LINES; i++) begin
            if ((board & WIN_LINES[i]) == WIN_LINES[i]) begin
                has_line = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ttt_turn_controller.sv
// Tic-tac-toe turn sequencer: takes human X moves, requests O moves from the
// AI with timeout/fallback, owns both boards and reports win or draw.
module ttt_turn_controller
    import ttt_pkg::*;
#(
    parameter int AI_TIMEOUT = 64,
    parameter bit X_FIRST    = 1'b1
) (
    input  logic                clk,
    input  logic                clr_n,
    input  logic                new_game,
    input  logic                btn_input,
    input  logic [3:0]          move_sel,
    output logic                ai_req,
    input  logic                ai_valid,
    input  logic [BOARD_W-1:0]  ai_move,
    output logic [BOARD_W-1:0]  x_state,
    output logic [BOARD_W-1:0]  o_state,
    output logic                o_turn,
    output logic                illegal,
    output logic                game_over,
    output logic [1:0]          winner,
    output logic [3:0]          move_count
);

    localparam state_e ENTRY = X_FIRST ? S_X_WAIT : S_AI_REQ;
    localparam int     TW    = $clog2(AI_TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(AI_TIMEOUT - 1);

    state_e             state;
    logic               btn_prev;
    logic [TW-1:0]      timer;

    logic [BOARD_W-1:0] occupied;
    logic [BOARD_W-1:0] sel_cell;
    logic [BOARD_W-1:0] fallback;
    logic               btn_rise;
    logic               x_legal;
    logic               ai_ok;
    logic               x_win;
    logic               o_win;

    assign occupied = x_state | o_state;
    assign btn_rise = btn_input & ~btn_prev;
    // Selections 9..15 shift the single bit out, leaving an empty mask.
    assign sel_cell = 9'd1 << move_sel;
    assign x_legal  = (move_sel <= 4'd8) && ((occupied & sel_cell) == '0);
    assign ai_ok    = (ai_move != '0) && ((ai_move & (ai_move - 9'd1)) == '0)
                      && ((ai_move & occupied) == '0);
    // Isolates the lowest zero bit of the occupancy mask: the lowest empty cell.
    assign fallback = ~occupied & (occupied + 9'd1);

    ttt_line_check u_x_line (.board(x_state), .has_line(x_win));
    ttt_line_check u_o_line (.board(o_state), .has_line(o_win));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state      <= ENTRY;
            btn_prev   <= 1'b0;
            timer      <= '0;
            x_state    <= '0;
            o_state    <= '0;
            move_count <= '0;
            winner     <= WIN_NONE;
            game_over  <= 1'b0;
            illegal    <= 1'b0;
            ai_req     <= 1'b0;
            o_turn     <= 1'b0;
        end else begin
            btn_prev <= btn_input;
            illegal  <= 1'b0;
            if (new_game) begin
                // Abort beats any same-cycle move; a late AI answer then lands in a state that ignores it.
                state      <= ENTRY;
                timer      <= '0;
                x_state    <= '0;
                o_state    <= '0;
                move_count <= '0;
                winner     <= WIN_NONE;
                game_over  <= 1'b0;
                ai_req     <= 1'b0;
                o_turn     <= 1'b0;
            end else begin
                unique case (state)
                    S_X_WAIT: begin
                        if (btn_rise) begin
                            if (x_legal) begin
                                x_state    <= x_state | sel_cell;
                                move_count <= move_count + 4'd1;
                                state      <= S_X_CHECK;
                            end else begin
                                illegal <= 1'b1;
                            end
                        end
                    end
                    S_X_CHECK: begin
                        if (x_win) begin
                            winner    <= WIN_X;
                            game_over <= 1'b1;
                            state     <= S_DONE;
                        end else if (move_count == 4'd9) begin
                            winner    <= WIN_DRAW;
                            game_over <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            state <= S_AI_REQ;
                        end
                    end
                    S_AI_REQ: begin
                        ai_req <= 1'b1;
                        o_turn <= 1'b1;
                        timer  <= '0;
                        state  <= S_AI_WAIT;
                    end
                    S_AI_WAIT: begin
                        if (ai_valid || timer == TIMER_LAST) begin
                            o_state    <= o_state | ((ai_valid && ai_ok) ? ai_move : fallback);
                            move_count <= move_count + 4'd1;
                            ai_req     <= 1'b0;
                            state      <= S_O_CHECK;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    S_O_CHECK: begin
                        o_turn <= 1'b0;
                        if (o_win) begin
                            winner    <= WIN_O;
                            game_over <= 1'b1;
                            state     <= S_DONE;
                        end else if (move_count == 4'd9) begin
                            winner    <= WIN_DRAW;
                            game_over <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            state <= S_X_WAIT;
                        end
                    end
                    S_DONE: begin
                        state <= S_DONE;
                    end
                    default: begin
                        state <= ENTRY;
                    end
                endcase
            end
        end
    end

endmodule
